// File: rtl/mem_layout_pkg.sv
// Memory layout constants and ID/address conversions shared by the link transmitter and receiver.
// Also holds the transmitter state type so monitors can decode it.
package mem_layout_pkg;

  localparam logic [31:0] MEM_BASE_ADDR  = 32'h4000_0000;
  localparam int unsigned ID_STRIDE_LOG2 = 2;
  localparam logic [15:0] ABS_ID_CEILING = 16'd255;
  localparam logic [31:0] ABS_ADDR_CEILING =
    MEM_BASE_ADDR + (32'(ABS_ID_CEILING) << ID_STRIDE_LOG2);

  typedef enum logic {IDLE, SEND} tx_state_t;

  function automatic logic [31:0] ID2ADDR(input logic [31:0] id);
    return MEM_BASE_ADDR + (id << ID_STRIDE_LOG2);
  endfunction

  // Addresses outside the mapped window clamp to the nearest valid ID.
  function automatic logic [15:0] ADDR2ID(input logic [31:0] addr);
    if (addr < MEM_BASE_ADDR)
      return '0;
    else if (addr >= ABS_ADDR_CEILING)
      return ABS_ID_CEILING;
    else
      return 16'((addr - MEM_BASE_ADDR) >> ID_STRIDE_LOG2);
  endfunction

endpackage

// File: rtl/axi_transmit.sv
// Serialises one DATA_WIDTH word (or memory ID mapped to its address) into BUS_WIDTH packets, LSB beat first.
// Optional AXI_TX_DROP_CNT_EN adds a saturating counter of words dropped while busy.
module axi_transmit
  import mem_layout_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  is_addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid_data,
  output logic [BUS_WIDTH-1:0]  packet,
  output logic                  valid_pack,
  input  logic                  pack_ready,
  output logic                  busy
`ifdef AXI_TX_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int unsigned PW     = (BUS_WIDTH > DATA_WIDTH) ? BUS_WIDTH : DATA_WIDTH;
  localparam int unsigned NBEATS = (PW + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int unsigned PLW    = NBEATS * BUS_WIDTH;
  localparam int unsigned BCW    = $clog2(NBEATS) + 1;
  localparam int unsigned IW     = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;

  tx_state_t        state;
  logic [PLW-1:0]   payload;
  logic [PLW-1:0]   payload_d;
  logic [BCW-1:0]   beat;
  logic [BCW-1:0]   beat_nxt;
  logic [IW-1:0]    id_wide;
  logic [31:0]      addr;

  // Out-of-range IDs map to the ceiling address, matching the receiver's clamp.
  always_comb begin
    id_wide   = IW'(data);
    addr      = (id_wide > IW'(ABS_ID_CEILING)) ? ID2ADDR(32'(ABS_ID_CEILING))
                                                : ID2ADDR(32'(id_wide));
    payload_d = is_addr ? PLW'(PW'(addr)) : PLW'(data);
    beat_nxt  = beat + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      payload    <= '0;
      packet     <= '0;
      valid_pack <= 1'b0;
      busy       <= 1'b0;
      beat       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_data) begin
            payload    <= payload_d;
            packet     <= payload_d[BUS_WIDTH-1:0];
            beat       <= '0;
            valid_pack <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (pack_ready) begin
            if (beat == BCW'(NBEATS - 1)) begin
              valid_pack <= 1'b0;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              beat   <= beat_nxt;
              packet <= payload[beat_nxt*BUS_WIDTH +: BUS_WIDTH];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_TX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (valid_data && busy && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_axi_transmit.sv
// Scoreboard bench for axi_transmit: an 8-bit (two-beat) and a 32-bit (one-beat) instance side by side.
// Define AXI_TX_DROP_CNT_EN for both RTL and bench to exercise the drop counter.
module tb_axi_transmit;
  import mem_layout_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d8 = '0, d32 = '0;
  logic        vd8 = 1'b0, vd32 = 1'b0, ia8 = 1'b0, ia32 = 1'b0;
  logic        rdy8 = 1'b0, rdy32 = 1'b0;
  logic [7:0]  pk8;
  logic [31:0] pk32;
  logic        vp8, vp32, bz8, bz32;
`ifdef AXI_TX_DROP_CNT_EN
  logic [15:0] dc8, dc32;
`endif

  axi_transmit #(.BUS_WIDTH(8), .DATA_WIDTH(16)) u8 (
    .clk(clk), .rst_n(rst_n), .is_addr(ia8), .data(d8), .valid_data(vd8),
    .packet(pk8), .valid_pack(vp8), .pack_ready(rdy8), .busy(bz8)
`ifdef AXI_TX_DROP_CNT_EN
    , .drop_cnt(dc8)
`endif
  );

  axi_transmit #(.BUS_WIDTH(32), .DATA_WIDTH(16)) u32 (
    .clk(clk), .rst_n(rst_n), .is_addr(ia32), .data(d32), .valid_data(vd32),
    .packet(pk32), .valid_pack(vp32), .pack_ready(rdy32), .busy(bz32)
`ifdef AXI_TX_DROP_CNT_EN
    , .drop_cnt(dc32)
`endif
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          drops_m [2] = '{0, 0};
  logic [31:0] q8 [$];
  logic [31:0] q32 [$];
  bit          prev_stall [2] = '{0, 0};
  logic [31:0] prev_pkt [2];
  bit          rand_rdy = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] get_pkt(input int idx);
    return (idx == 0) ? {24'h0, pk8} : pk32;
  endfunction
  function automatic logic get_vp(input int idx);
    return (idx == 0) ? vp8 : vp32;
  endfunction
  function automatic logic get_busy(input int idx);
    return (idx == 0) ? bz8 : bz32;
  endfunction
  function automatic logic get_rdy(input int idx);
    return (idx == 0) ? rdy8 : rdy32;
  endfunction

  task automatic set_in(input int idx, input logic v, input logic [15:0] d, input logic ia);
    if (idx == 0) begin vd8 = v; d8 = d; ia8 = ia; end
    else begin vd32 = v; d32 = d; ia32 = ia; end
  endtask

  // Reference: build the payload from the word/ID rules, then cut it into beats LSB first.
  task automatic model_push(input int idx, input logic [15:0] d, input logic ia);
    int unsigned bw = (idx == 0) ? 8 : 32;
    int unsigned pw = (idx == 0) ? 16 : 32;
    int unsigned nb = (idx == 0) ? 2 : 1;
    logic [63:0] payload;
    logic [15:0] id;
    if (ia) begin
      id = (d > ABS_ID_CEILING) ? ABS_ID_CEILING : d;
      payload = 64'(ID2ADDR(32'(id)));
    end else begin
      payload = 64'(d);
    end
    payload = payload & ((64'd1 << pw) - 64'd1);
    for (int unsigned i = 0; i < nb; i++) begin
      if (idx == 0) q8.push_back(32'((payload >> (i * bw)) & ((64'd1 << bw) - 64'd1)));
      else          q32.push_back(32'((payload >> (i * bw)) & ((64'd1 << bw) - 64'd1)));
    end
  endtask

  task automatic mon(input int idx);
    logic        vp = get_vp(idx);
    logic        rd = get_rdy(idx);
    logic [31:0] pk = get_pkt(idx);
    logic [31:0] exp;
    if (!rst_n) begin
      prev_stall[idx] = 0;
      return;
    end
    if (prev_stall[idx])
      check(vp && (pk == prev_pkt[idx]), (idx == 0) ? "hold8" : "hold32", pk, prev_pkt[idx]);
    check(get_busy(idx) == vp, (idx == 0) ? "busy_eq_valid8" : "busy_eq_valid32",
          32'(get_busy(idx)), 32'(vp));
    if (vp && rd) begin
      if ((idx == 0 && q8.size() == 0) || (idx == 1 && q32.size() == 0)) begin
        check(0, (idx == 0) ? "unexpected_beat8" : "unexpected_beat32", pk, 32'hx);
      end else begin
        exp = (idx == 0) ? q8.pop_front() : q32.pop_front();
        check(pk == exp, (idx == 0) ? "beat8" : "beat32", pk, exp);
      end
    end
    prev_stall[idx] = vp && !rd;
    prev_pkt[idx]   = pk;
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) begin
      rdy8  = ($urandom_range(0, 3) != 0);
      rdy32 = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int idx, input logic [15:0] d, input logic ia);
    int n = 0;
    @(posedge clk); #1;
    while (get_busy(idx) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      check(0, "idle_timeout", 32'(get_busy(idx)), 32'h0);
      return;
    end
    set_in(idx, 1'b1, d, ia);
    model_push(idx, d, ia);
    @(posedge clk); #1;
    set_in(idx, 1'b0, '0, 1'b0);
    check(get_vp(idx) && get_busy(idx), "load_latency", {get_vp(idx), get_busy(idx)}, 32'h3);
  endtask

  task automatic drop(input int idx, input logic [15:0] d);
    if (get_busy(idx)) drops_m[idx]++;
    set_in(idx, 1'b1, d, 1'b0);
    @(posedge clk); #1;
    set_in(idx, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_idle(input int idx);
    int n = 0;
    while (get_busy(idx) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check(0, "drain_timeout", 32'(get_busy(idx)), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check(!vp8 && !bz8 && pk8 == 8'h0, "reset8", {vp8, bz8, pk8}, 32'h0);
    check(!vp32 && !bz32 && pk32 == 32'h0, "reset32", pk32 | {vp32, bz32}, 32'h0);
`ifdef AXI_TX_DROP_CNT_EN
    check(dc8 == 16'h0, "reset_drop8", 32'(dc8), 32'h0);
`endif
    rst_n = 1'b1;

    // Two beats with continuous ready, then one idle cycle.
    rdy8 = 1'b1;
    send(0, 16'hA5C3, 1'b0);
    check(pk8 == 8'hC3, "two_beat_b0", 32'(pk8), 32'hC3);
    @(posedge clk); #1;
    check(pk8 == 8'hA5 && bz8, "two_beat_b1", 32'(pk8), 32'hA5);
    @(posedge clk); #1;
    check(!vp8 && !bz8, "two_beat_idle", {vp8, bz8}, 32'h0);

    // Zero extension on the wide link.
    rdy32 = 1'b1;
    send(1, 16'hBEEF, 1'b0);
    check(pk32 == 32'h0000BEEF, "zero_ext", pk32, 32'h0000BEEF);

    // Backpressure on beat 1: the high byte stays up for four cycles.
    send(0, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rdy8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check(vp8 && pk8 == 8'h12, "bp_hold", 32'(pk8), 32'h12);
      @(posedge clk); #1;
    end
    check(vp8 && pk8 == 8'h12, "bp_hold_last", 32'(pk8), 32'h12);
    rdy8 = 1'b1;
    @(posedge clk); #1;
    check(!vp8 && !bz8, "bp_done", {vp8, bz8}, 32'h0);

    // ID mapping and the ceiling clamp, recovered through the receiver's conversion.
    send(1, 16'd3, 1'b1);
    check(ADDR2ID(pk32) == 16'd3, "addr_id3", 32'(ADDR2ID(pk32)), 32'd3);
    send(1, ABS_ID_CEILING + 16'd5, 1'b1);
    check(ADDR2ID(pk32) == ABS_ID_CEILING, "addr_clamp", 32'(ADDR2ID(pk32)), 32'(ABS_ID_CEILING));

    // Drops while busy leave the held word intact.
    rdy8 = 1'b0;
    send(0, 16'h5A69, 1'b0);
    drop(0, 16'hFFFF);
    @(posedge clk); #1;
    drop(0, 16'h0000);
    rdy8 = 1'b1;
    wait_idle(0);
`ifdef AXI_TX_DROP_CNT_EN
    check(dc8 == 16'd2, "drop_cnt2", 32'(dc8), 32'd2);
`endif

    // Reset during beat 0 aborts the word.
    rdy32 = 1'b0;
    send(1, 16'hCAFE, 1'b0);
    rst_n = 1'b0;
    q32.delete();
    q8.delete();
    drops_m[0] = 0;
    drops_m[1] = 0;
    @(posedge clk); #1;
    check(!vp32 && !bz32 && pk32 == 32'h0, "reset_abort", pk32 | {vp32, bz32}, 32'h0);
`ifdef AXI_TX_DROP_CNT_EN
    check(dc8 == 16'd0, "reset_drop_clear", 32'(dc8), 32'd0);
`endif
    rst_n = 1'b1;
    rdy32 = 1'b1;
    send(1, 16'h7777, 1'b0);
    check(pk32 == 32'h00007777, "after_reset", pk32, 32'h00007777);

    // Randomized traffic on both links with random ready and occasional drops.
    rand_rdy = 1;
    fork
      for (int i = 0; i < 40; i++) begin
        logic ia = 1'($urandom_range(0, 1));
        send(0, ia ? 16'($urandom_range(0, 300)) : 16'($urandom), ia);
        if ($urandom_range(0, 3) == 0) drop(0, 16'($urandom));
      end
      for (int j = 0; j < 40; j++) begin
        logic ia = 1'($urandom_range(0, 1));
        send(1, ia ? 16'($urandom_range(0, 300)) : 16'($urandom), ia);
        if ($urandom_range(0, 3) == 0) drop(1, 16'($urandom));
      end
    join
    rand_rdy = 0;
    @(posedge clk); #1;
    rdy8 = 1'b1;
    rdy32 = 1'b1;
    wait_idle(0);
    wait_idle(1);
    @(posedge clk); #1;
    check(q8.size() == 0, "drain8", 32'(q8.size()), 32'h0);
    check(q32.size() == 0, "drain32", 32'(q32.size()), 32'h0);
`ifdef AXI_TX_DROP_CNT_EN
    check(dc8 == 16'(drops_m[0]), "rand_drop8", 32'(dc8), 32'(drops_m[0]));
    check(dc32 == 16'(drops_m[1]), "rand_drop32", 32'(dc32), 32'(drops_m[1]));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_transmit.md
# axi_transmit

Transmit side of the packetised Recieve_Transmit_IF link. It latches one DATA_WIDTH word (or memory ID), optionally maps an ID back to its absolute address, and serialises it into BUS_WIDTH packets, least-significant beat first. Packets carry valid/ready flow control. It sits between PS-facing register logic and the AXI-lite read-data/address path, and its output reassembles correctly in the existing packet receiver.

## Interface
- BUS_WIDTH, 32, packet width on the link
- DATA_WIDTH, 16, word width presented by the producer
- clk  in  1  single system clock
- rst_n  in  1  reset; synchronous, active-low
- is_addr  in  1  sampled with the word; 1 = word is a memory ID and is converted to an address
- bus.data  in  DATA_WIDTH  word or ID from producer
- bus.valid_data  in  1  word valid; accepted only when busy = 0
- bus.packet  out  BUS_WIDTH  current beat
- bus.valid_pack  out  1  beat valid
- pack_ready  in  1  consumer accepts the beat on this edge when valid_pack = 1
- busy  out  1  registered; 1 from the cycle after acceptance until the last beat is accepted
- drop_cnt  out  16  present only with AXI_TX_DROP_CNT_EN

## Operation
- Payload width: PW = max(BUS_WIDTH, DATA_WIDTH). NBEATS = ceil(PW / BUS_WIDTH); NBEATS = 1 when BUS_WIDTH >= DATA_WIDTH.
- Address mapping when is_addr = 1:
  - If ID <= ABS_ID_CEILING, the payload is ID2ADDR(ID).
  - Otherwise the payload is ID2ADDR(ABS_ID_CEILING), mirroring the receiver's clamp.
  - The result is zero-extended or truncated to PW.
- When is_addr = 0, the payload is the word zero-extended to NBEATS*BUS_WIDTH.
- FSM has two states:
  - IDLE: busy = 0, valid_pack = 0. valid_data = 1 latches the payload and sets beat = 0, then moves to SEND.
  - SEND: valid_pack = 1 and packet = payload[beat*BUS_WIDTH +: BUS_WIDTH].
    - On pack_ready with beat < NBEATS-1: beat increments.
    - On pack_ready with beat = NBEATS-1: return to IDLE.
- Backpressure: while valid_pack = 1 and pack_ready = 0, packet and valid_pack are held stable. valid_pack is never withdrawn.
- valid_data while busy = 1 is dropped; the held payload is unaffected.
- The beat counter is $clog2(NBEATS)+1 bits and never wraps past NBEATS-1.

## Timing
- Reset values: valid_pack = 0, packet = 0, busy = 0, beat = 0, drop_cnt = 0, state = IDLE.
- Reset mid-transfer aborts the word with no partial completion; the next edge after release is IDLE.
- Latency: valid_data accepted at edge N gives valid_pack = 1 and beat 0 on the link during cycle N+1.
- Minimum word period is NBEATS+1 cycles. There is one IDLE cycle between words; back-to-back acceptance in the last-beat cycle is not supported.
- packet is registered and changes only on an accepted beat or on load.

## Configuration
- AXI_TX_DROP_CNT_EN defined:
  - drop_cnt counts valid_data = 1 cycles that occur while busy = 1.
  - It saturates at 16'hFFFF and clears only on reset.
- AXI_TX_DROP_CNT_EN undefined: the drop_cnt port and its logic are absent; drops are silent.

## Structure
- ABS_ID_CEILING, ABS_ADDR_CEILING, ADDR2ID and ID2ADDR live in mem_layout_pkg. ID2ADDR is added there beside ADDR2ID if missing.
- The tx_state_t enum (IDLE, SEND) goes in mem_layout_pkg for reuse by bench monitors.
- NBEATS and PW are localparams.
- Single module, no sub-module; address mapping is inline combinational logic on the load path.

## Test plan
- Two beats: DW=16, BW=8, pack_ready=1, data=16'hA5C3, is_addr=0 -> packets 8'hC3 then 8'hA5 on consecutive cycles; busy high 2 cycles; idle 1 cycle.
- Zero-extension: DW=16, BW=32, data=16'hBEEF -> single packet 32'h0000BEEF one cycle after valid_data.
- Backpressure: DW=16, BW=8, pack_ready low 3 cycles on beat 1 of 16'h1234 -> 8'h12 held stable and valid 4 cycles; no duplicate or lost beat.
- Address mapping: is_addr=1 with ID=3 -> payload ID2ADDR(3). With ID=ABS_ID_CEILING+5 -> payload ID2ADDR(ABS_ID_CEILING). Looped into the receiver with is_addr=1, the recovered IDs are 3 and ABS_ID_CEILING.
- Drops and reset: pulse valid_data twice during a transfer -> original payload completes and drop_cnt = 2 (macro on). Assert rst_n=0 during beat 0 -> valid_pack=0 and busy=0 next edge; the following word transfers cleanly.
